// File: rtl/mem_access_master.sv
// Initiator for the 128-word data memory: byte stores and 1..MAX_BURST word
// read bursts, with per-beat range checking and fully registered outputs.
module mem_access_master #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int BW        = 8,
  parameter int MEM_DEPTH = 128,
  parameter int MAX_BURST = 4,
  localparam int LW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic [BW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic [BW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          rsp_err_q, rsp_err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [BW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic          accept;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(MEM_DEPTH));
  endfunction

  assign accept = req_valid & req_ready_q & (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = !req_we ? S_READ : (in_range(req_addr) ? S_WRITE : S_RESP);
      S_READ:  state_d = S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = rsp_last_q ? S_IDLE : S_READ;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs follow the next state so they are registered alongside it.
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    mem_we_d    = (state_d == S_WRITE);
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    case (state_q)
      S_IDLE: if (accept) begin
        addr_d     = req_addr;
        len_d      = req_we ? '0 : req_len;
        beat_d     = '0;
        mem_addr_d = req_addr;
        if (req_we) begin
          mem_wdata_d = req_wdata;
          // Out-of-range store skips WRITE and goes straight to an error ack.
          if (!in_range(req_addr)) begin
            rsp_data_d = '0;
            rsp_last_d = 1'b1;
            rsp_err_d  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        rsp_data_d = '0;
        rsp_last_d = 1'b1;
        rsp_err_d  = 1'b0;
      end
      S_READ: begin
        rsp_data_d = in_range(addr_q) ? mem_rdata : '0;
        rsp_err_d  = !in_range(addr_q);
        rsp_last_d = (beat_q == len_q);
      end
      S_RESP: if (rsp_ready && !rsp_last_q) begin
        addr_d     = addr_q + 1'b1;
        mem_addr_d = addr_q + 1'b1;
        beat_d     = beat_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a behavioural 128-word memory
// (byte-lane writes, combinational reads).
module tb_mem_access_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready;
  logic [7:0]  req_addr, req_wdata;
  logic [1:0]  req_len;
  logic        req_ready, rsp_valid, rsp_last, rsp_err, mem_we, busy;
  logic [31:0] rsp_data, mem_rdata;
  logic [7:0]  mem_addr, mem_wdata;

  logic [31:0] mem [0:127];
  logic [31:0] exp_d [4];
  logic        exp_e [4];
  int          total = 0, fails = 0, we_cnt = 0, we_base;

  mem_access_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 8'd128) ? mem[mem_addr[6:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr < 8'd128) mem[mem_addr[6:0]][7:0] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Read burst with rsp_ready held high; expectations come from exp_d/exp_e.
  task automatic do_read(input logic [7:0] a, input logic [1:0] l);
    logic [7:0] ba;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = l; rsp_ready = 1'b1;
    tick();
    chk("acc_ready", req_ready, 0);
    chk("acc_busy", busy, 1);
    chk("acc_valid", rsp_valid, 0);
    req_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      if (i > 0) begin
        tick();
        chk("read_gap_valid", rsp_valid, 0);
      end
      tick();
      ba = a + 8'(i);
      chk("beat_valid", rsp_valid, 1);
      chk("beat_data", rsp_data, exp_d[i]);
      chk("beat_last", rsp_last, (i == int'(l)) ? 1 : 0);
      chk("beat_err", rsp_err, exp_e[i]);
      chk("beat_addr", mem_addr, ba);
    end
    tick();
    chk("end_valid", rsp_valid, 0);
    chk("end_ready", req_ready, 1);
    chk("end_busy", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h100 + i;
    mem[64] = 24; mem[65] = 24; mem[66] = 25; mem[67] = 26;
    mem[126] = 32'h1234_5678; mem[127] = 32'hCAFE_F00D;
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_len = 0;
    req_wdata = 0; rsp_ready = 0;
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", {rsp_data[31:2], rsp_last, rsp_err}, 0);
    rst_n = 1'b1;
    #1 chk("rel_ready_pre", req_ready, 0);
    tick();
    chk("rel_ready", req_ready, 1);

    // Burst read 64..67
    exp_d = '{24, 24, 25, 26}; exp_e = '{0, 0, 0, 0};
    do_read(8'd64, 2'd3);

    // Byte store 0xAB to 65, then read it back
    we_base = we_cnt;
    req_valid = 1; req_we = 1; req_addr = 65; req_wdata = 8'hAB; rsp_ready = 1;
    tick();
    req_valid = 0;
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 65);
    chk("st_wdata", mem_wdata, 8'hAB);
    chk("st_valid_early", rsp_valid, 0);
    tick();
    chk("st_we_off", mem_we, 0);
    chk("st_ack_valid", rsp_valid, 1);
    chk("st_ack", {rsp_data, rsp_last, rsp_err}, {32'd0, 1'b1, 1'b0});
    tick();
    chk("st_idle", req_ready, 1);
    chk("st_we_cnt", we_cnt - we_base, 1);
    exp_d[0] = 32'h0000_00AB; exp_e[0] = 0;
    do_read(8'd65, 2'd0);

    // Burst crossing the end of memory
    exp_d = '{32'h1234_5678, 32'hCAFE_F00D, 0, 0}; exp_e = '{0, 0, 1, 1};
    do_read(8'd126, 2'd3);

    // Out-of-range store: error ack, no write strobe
    we_base = we_cnt;
    req_valid = 1; req_we = 1; req_addr = 200; req_wdata = 8'h55;
    tick();
    req_valid = 0;
    chk("oor_we", mem_we, 0);
    chk("oor_valid", rsp_valid, 1);
    chk("oor_ack", {rsp_data, rsp_last, rsp_err}, {32'd0, 1'b1, 1'b1});
    tick();
    chk("oor_idle", req_ready, 1);
    chk("oor_we_cnt", we_cnt - we_base, 0);

    // Backpressure on beat 2 (mem[65] now 0xAB)
    req_valid = 1; req_we = 0; req_addr = 64; req_len = 3; rsp_ready = 1;
    tick(); req_valid = 0;
    tick(); chk("bp_b0", rsp_data, 24);
    tick(); tick();
    chk("bp_b1", rsp_data, 32'hAB);
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 32'hAB);
      chk("bp_hold_addr", mem_addr, 65);
      chk("bp_hold_last", rsp_last, 0);
    end
    rsp_ready = 1;
    tick(); chk("bp_adv_addr", mem_addr, 66);
    tick(); chk("bp_b2", rsp_data, 25);
    tick(); tick();
    chk("bp_b3", {rsp_data, rsp_last, rsp_err}, {32'd26, 1'b1, 1'b0});
    tick(); chk("bp_idle", busy, 0);

    // Second request held during a burst is only accepted after it ends
    req_valid = 1; req_we = 0; req_addr = 64; req_len = 1;
    tick();
    req_addr = 66; req_len = 0;
    tick(); chk("bz_ready0", req_ready, 0); chk("bz_data0", rsp_data, 24);
    tick(); chk("bz_ready1", req_ready, 0); chk("bz_addr1", mem_addr, 65);
    tick(); chk("bz_data1", {rsp_data, rsp_last}, {32'hAB, 1'b1});
    tick(); chk("bz_ready_back", req_ready, 1);
    tick();
    req_valid = 0;
    chk("bz_accept", req_ready, 0);
    chk("bz_addr2", mem_addr, 66);
    tick(); chk("bz_data2", {rsp_data, rsp_last}, {32'd25, 1'b1});
    tick(); chk("bz_idle", busy, 0);

    // Reset in the middle of beat 2's response
    req_valid = 1; req_we = 0; req_addr = 64; req_len = 3; rsp_ready = 1;
    tick(); req_valid = 0;
    tick(); tick(); tick();
    rsp_ready = 0;
    chk("mr_in_resp", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", rsp_valid, 0);
    chk("mr_we", mem_we, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("mr_ready_pre", req_ready, 0);
    tick();
    chk("mr_ready_post", req_ready, 1);
    chk("mr_no_rsp", rsp_valid, 0);
    exp_d[0] = 24; exp_e[0] = 0;
    do_read(8'd64, 2'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
